wb_slave_arbiter: RTL and testbench

WB_SLAVE_ARBITER -- requirements
Module: wb_slave_arbiter

---
 rtl/wb_slave_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_wb_slave_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_arbiter.sv
// ---------------------------------------------------------------------------
// wb_slave_arbiter
//
// Purpose: shares one Wishbone slave between two Wishbone masters. The bus
// is arbitrated from an IDLE state only; once a master owns the bus it keeps
// it for as long as it holds cyc, so multi-beat cycles are never split.
// Simultaneous requests from IDLE go to the master that did not own the bus
// last (m0 wins the first tie after reset).
//
// Handshake: a master's cyc is its request. The grant is registered, so the
// slave sees the request one cycle after it is first sampled. While a
// master owns the bus, its cyc/stb/we/sel/dat/adr are passed combinationally
// to the slave, and the slave's ack/dat are passed combinationally back to
// that master only. The arbiter never creates, holds or drops an ack. Any
// ack-until-stb-drops behaviour of the slave passes through unchanged.
//
// Optional feature (macro ARB_TIMEOUT_EN): a 16-bit stall counter aborts a
// grant whose strobed access has waited TIMEOUT cycles without an ack. The
// abort pulses o_timeout during the last granted cycle; the aborted master
// must drop cyc before it can be granted again. Without the macro there is
// no counter, o_timeout is 0 and a grant is held indefinitely.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   i_m{0,1}_cyc/stb/we      master request controls
//   i_m{0,1}_sel/dat/adr     master byte select, write data, address
//   o_m{0,1}_ack/dat         slave response, routed to the owning master only
//   o_m{0,1}_int             slave interrupt, broadcast to both masters
//   o_s_cyc/stb/we/sel/dat/adr  shared-slave request (zero when idle)
//   i_s_ack/dat/int          shared-slave response
//   o_timeout                one-cycle pulse on a timeout abort
//   o_grant                  one-hot owner: 01 = m0, 10 = m1, 00 = none
//                            (this is also the full FSM state view)
// ---------------------------------------------------------------------------
module wb_slave_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  // master 0
  input  logic        i_m0_we,
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  input  logic [3:0]  i_m0_sel,
  input  logic [31:0] i_m0_dat,
  input  logic [31:0] i_m0_adr,
  output logic        o_m0_ack,
  output logic [31:0] o_m0_dat,
  output logic        o_m0_int,
  // master 1
  input  logic        i_m1_we,
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  input  logic [3:0]  i_m1_sel,
  input  logic [31:0] i_m1_dat,
  input  logic [31:0] i_m1_adr,
  output logic        o_m1_ack,
  output logic [31:0] o_m1_dat,
  output logic        o_m1_int,
  // shared slave
  output logic        o_s_we,
  output logic        o_s_cyc,
  output logic        o_s_stb,
  output logic [3:0]  o_s_sel,
  output logic [31:0] o_s_dat,
  output logic [31:0] o_s_adr,
  input  logic        i_s_ack,
  input  logic [31:0] i_s_dat,
  input  logic        i_s_int,
  // status
  output logic        o_timeout,
  output logic [1:0]  o_grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  // Last owner: 0 = m0, 1 = m1. Resets to m1 so m0 wins the first tie.
  logic   last_q, last_d;
  logic   timeout_hit;
  logic   req0, req1;

`ifdef ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  // Per-master abort lockout: set when that master's grant is aborted,
  // cleared once the master lets go of cyc.
  logic [1:0]  blk_q, blk_d;

  assign timeout_hit = (state_q != IDLE) && (cnt_q == TIMEOUT);
  assign req0        = i_m0_cyc & ~blk_q[0];
  assign req1        = i_m1_cyc & ~blk_q[1];

  always_comb begin
    cnt_d = cnt_q;
    blk_d = blk_q & {i_m1_cyc, i_m0_cyc};
    // The counter sits at 0 in IDLE, which makes every grant start from 0.
    if (state_q == IDLE) begin
      cnt_d = 16'd0;
    end else if (i_s_ack) begin
      cnt_d = 16'd0;
    end else if (o_s_stb) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (timeout_hit) begin
      if (state_q == GRANT0) blk_d[0] = 1'b1;
      if (state_q == GRANT1) blk_d[1] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
      blk_q <= 2'b00;
    end else begin
      cnt_q <= cnt_d;
      blk_q <= blk_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign req0           = i_m0_cyc;
  assign req1           = i_m1_cyc;
`endif

  assign o_timeout = timeout_hit;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? GRANT0 : GRANT1;
        end else if (req0) begin
          state_d = GRANT0;
        end else if (req1) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        if (!i_m0_cyc || timeout_hit) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      GRANT1: begin
        if (!i_m1_cyc || timeout_hit) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Datapath muxing, purely from the registered owner
  always_comb begin
    o_s_we   = 1'b0;
    o_s_cyc  = 1'b0;
    o_s_stb  = 1'b0;
    o_s_sel  = 4'h0;
    o_s_dat  = 32'h0;
    o_s_adr  = 32'h0;
    o_m0_ack = 1'b0;
    o_m0_dat = 32'h0;
    o_m1_ack = 1'b0;
    o_m1_dat = 32'h0;
    o_grant  = 2'b00;
    unique case (state_q)
      GRANT0: begin
        o_s_we   = i_m0_we;
        o_s_cyc  = i_m0_cyc;
        o_s_stb  = i_m0_stb;
        o_s_sel  = i_m0_sel;
        o_s_dat  = i_m0_dat;
        o_s_adr  = i_m0_adr;
        o_m0_ack = i_s_ack;
        o_m0_dat = i_s_dat;
        o_grant  = 2'b01;
      end
      GRANT1: begin
        o_s_we   = i_m1_we;
        o_s_cyc  = i_m1_cyc;
        o_s_stb  = i_m1_stb;
        o_s_sel  = i_m1_sel;
        o_s_dat  = i_m1_dat;
        o_s_adr  = i_m1_adr;
        o_m1_ack = i_s_ack;
        o_m1_dat = i_s_dat;
        o_grant  = 2'b10;
      end
      default: ;
    endcase
  end

  // Interrupt is broadcast in every state, including reset.
  assign o_m0_int = i_s_int;
  assign o_m1_int = i_s_int;

endmodule

// File: tb/tb_wb_slave_arbiter.sv
module tb_wb_slave_arbiter;

  localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_dat, m0_adr, m1_dat, m1_adr;
  logic        o_m0_ack, o_m0_int, o_m1_ack, o_m1_int;
  logic [31:0] o_m0_dat, o_m1_dat;
  logic        o_s_we, o_s_cyc, o_s_stb;
  logic [3:0]  o_s_sel;
  logic [31:0] o_s_dat, o_s_adr;
  logic        s_ack, s_int;
  logic [31:0] s_dat;
  logic        o_timeout;
  logic [1:0]  o_grant;

  wb_slave_arbiter #(.TIMEOUT(16'(TO))) dut (
    .clk(clk), .rst(rst),
    .i_m0_we(m0_we), .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb),
    .i_m0_sel(m0_sel), .i_m0_dat(m0_dat), .i_m0_adr(m0_adr),
    .o_m0_ack(o_m0_ack), .o_m0_dat(o_m0_dat), .o_m0_int(o_m0_int),
    .i_m1_we(m1_we), .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb),
    .i_m1_sel(m1_sel), .i_m1_dat(m1_dat), .i_m1_adr(m1_adr),
    .o_m1_ack(o_m1_ack), .o_m1_dat(o_m1_dat), .o_m1_int(o_m1_int),
    .o_s_we(o_s_we), .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb),
    .o_s_sel(o_s_sel), .o_s_dat(o_s_dat), .o_s_adr(o_s_adr),
    .i_s_ack(s_ack), .i_s_dat(s_dat), .i_s_int(s_int),
    .o_timeout(o_timeout), .o_grant(o_grant)
  );

  // ---------------- reference model ----------------
  // owner: -1 = nobody, 0 = m0, 1 = m1. last: index of previous owner.
  int m_owner;
  int m_last;
  int m_cnt;
  bit m_blk [2];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit nb [2];
    bit r0, r1;
    bit cyc_n, stb_n;
    if (rst) begin
      m_owner = -1; m_last = 1; m_cnt = 0; m_blk[0] = 0; m_blk[1] = 0;
    end else begin
      nb[0] = m_blk[0] && m0_cyc;
      nb[1] = m_blk[1] && m1_cyc;
      if (m_owner < 0) begin
        r0 = m0_cyc && !(TO_EN && m_blk[0]);
        r1 = m1_cyc && !(TO_EN && m_blk[1]);
        if (r0 && r1) m_owner = 1 - m_last;
        else if (r0)  m_owner = 0;
        else if (r1)  m_owner = 1;
        m_cnt = 0;
      end else begin
        cyc_n = (m_owner == 0) ? m0_cyc : m1_cyc;
        stb_n = (m_owner == 0) ? m0_stb : m1_stb;
        if (!cyc_n) begin
          m_last = m_owner; m_owner = -1; m_cnt = 0;
        end else if (TO_EN && m_cnt == TO) begin
          nb[m_owner] = 1;
          m_last = m_owner; m_owner = -1; m_cnt = 0;
        end else if (s_ack) begin
          m_cnt = 0;
        end else if (stb_n) begin
          m_cnt = m_cnt + 1;
        end
      end
      m_blk[0] = nb[0];
      m_blk[1] = nb[1];
    end
  endtask

  task automatic check_all();
    logic [1:0]  g;
    logic        we, cyc, stb;
    logic [3:0]  sel;
    logic [31:0] dat, adr;
    g = 2'b00; we = 0; cyc = 0; stb = 0; sel = 0; dat = 0; adr = 0;
    if (m_owner == 0) begin
      g = 2'b01; we = m0_we; cyc = m0_cyc; stb = m0_stb; sel = m0_sel; dat = m0_dat; adr = m0_adr;
    end else if (m_owner == 1) begin
      g = 2'b10; we = m1_we; cyc = m1_cyc; stb = m1_stb; sel = m1_sel; dat = m1_dat; adr = m1_adr;
    end
    chk("grant",  32'(o_grant), 32'(g));
    chk("s_we",   32'(o_s_we),  32'(we));
    chk("s_cyc",  32'(o_s_cyc), 32'(cyc));
    chk("s_stb",  32'(o_s_stb), 32'(stb));
    chk("s_sel",  32'(o_s_sel), 32'(sel));
    chk("s_dat",  o_s_dat, dat);
    chk("s_adr",  o_s_adr, adr);
    chk("m0_ack", 32'(o_m0_ack), (m_owner == 0) ? 32'(s_ack) : 32'd0);
    chk("m0_dat", o_m0_dat, (m_owner == 0) ? s_dat : 32'h0);
    chk("m1_ack", 32'(o_m1_ack), (m_owner == 1) ? 32'(s_ack) : 32'd0);
    chk("m1_dat", o_m1_dat, (m_owner == 1) ? s_dat : 32'h0);
    chk("m0_int", 32'(o_m0_int), 32'(s_int));
    chk("m1_int", 32'(o_m1_int), 32'(s_int));
    chk("timeout", 32'(o_timeout),
        32'((TO_EN && m_owner >= 0 && m_cnt == TO) ? 1 : 0));
  endtask

  // ---------------- driver tasks ----------------
  // Check outputs against the current inputs, then advance one edge.
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic m0_set(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat);
    m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat = dat; m0_sel = 4'hF;
  endtask

  task automatic m1_set(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat);
    m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat = dat; m1_sel = 4'hF;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ack_pct;
    rst = 1'b1;
    m0_set(0, 0, 0, 0, 0); m1_set(0, 0, 0, 0, 0);
    s_ack = 0; s_dat = 32'h0; s_int = 0;
    @(posedge clk); model_step(); #1;

    // reset state, with interrupt still passing through
    s_int = 1'b1;
    tick();
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_s_cyc", 32'(o_s_cyc), 32'd0);
    chk("rst_int",   32'(o_m1_int), 32'd1);
    s_int = 1'b0;
    rst = 1'b0;

    // single write from m0
    m0_set(1, 1, 1, 32'h1, 32'hDEADBEEF);
    tick();
    chk("wr_grant", 32'(o_grant), 32'h1);
    chk("wr_s_adr", o_s_adr, 32'h1);
    chk("wr_s_dat", o_s_dat, 32'hDEADBEEF);
    s_ack = 1'b1;
    #1;
    chk("wr_m0_ack", 32'(o_m0_ack), 32'd1);
    chk("wr_m1_ack", 32'(o_m1_ack), 32'd0);
    tick();
    m0_set(0, 0, 0, 0, 0); s_ack = 1'b0;
    tick(); tick();

    // tie after reset goes to m0, then alternation
    rst = 1'b1; tick(); rst = 1'b0;
    m0_set(1, 1, 0, 32'h10, 0); m1_set(1, 1, 0, 32'h20, 0);
    tick();
    chk("tie_first", 32'(o_grant), 32'h1);
    m0_cyc = 0;
    tick();
    chk("tie_gap", 32'(o_grant), 32'h0);
    tick();
    chk("tie_m1", 32'(o_grant), 32'h2);
    m0_cyc = 1;
    m1_cyc = 0;
    tick();
    m1_cyc = 1;
    tick();
    chk("tie_alt", 32'(o_grant), 32'h1);
    m0_set(0, 0, 0, 0, 0); m1_set(0, 0, 0, 0, 0);
    tick(); tick();

    // m1 read
    m1_set(1, 1, 0, 32'h2, 0);
    tick();
    chk("rd_grant", 32'(o_grant), 32'h2);
    s_dat = 32'h2; s_ack = 1'b1;
    #1;
    chk("rd_m1_dat", o_m1_dat, 32'h2);
    chk("rd_m0_dat", o_m0_dat, 32'h0);
    tick();
    m1_set(0, 0, 0, 0, 0); s_ack = 1'b0; s_dat = 32'h0;
    tick(); tick();

    // m0 three-beat cycle while m1 waits
    m0_set(1, 0, 1, 0, 0); m1_set(1, 1, 0, 32'h44, 0);
    tick();
    for (int b = 0; b < 3; b++) begin
      m0_stb = 1; m0_adr = 32'(b); m0_dat = $urandom;
      tick();
      s_ack = 1;
      tick();
      s_ack = 0; m0_stb = 0;
      tick();
      chk("burst_hold", 32'(o_grant), 32'h1);
    end
    m0_cyc = 0;
    tick();
    chk("burst_gap", 32'(o_grant), 32'h0);
    tick();
    chk("burst_m1", 32'(o_grant), 32'h2);
    m1_set(0, 0, 0, 0, 0);
    tick(); tick();

    // slave never acks
    m0_set(1, 1, 0, 32'h80, 0);
    tick();
`ifdef ARB_TIMEOUT_EN
    repeat (TO) tick();
    chk("to_pulse", 32'(o_timeout), 32'd1);
    tick();
    chk("to_after", 32'(o_timeout), 32'd0);
    chk("to_s_cyc", 32'(o_s_cyc), 32'd0);
    chk("to_grant", 32'(o_grant), 32'd0);
    tick();
    chk("to_locked", 32'(o_grant), 32'd0);
`else
    repeat (110) tick();
    chk("hold_grant", 32'(o_grant), 32'h1);
    chk("hold_s_cyc", 32'(o_s_cyc), 32'd1);
`endif
    m0_set(0, 0, 0, 0, 0);
    tick(); tick();

    // reset in the middle of an m1 access
    m1_set(1, 1, 1, 32'h99, 32'h1234);
    tick();
    chk("mr_grant", 32'(o_grant), 32'h2);
    rst = 1'b1;
    tick();
    chk("mr_s_cyc", 32'(o_s_cyc), 32'd0);
    chk("mr_grant0", 32'(o_grant), 32'd0);
    rst = 1'b0;
    m0_set(1, 1, 0, 32'h5, 0);
    tick();
    chk("mr_tie", 32'(o_grant), 32'h1);
    m0_set(0, 0, 0, 0, 0); m1_set(0, 0, 0, 0, 0);
    tick();

    // randomized traffic
    ack_pct = 50;
    for (int i = 0; i < 800; i++) begin
      if (i % 64 == 0) ack_pct = ($urandom_range(0, 3) == 0) ? 0 : 50;
      if (m0_cyc) begin
        if ($urandom_range(0, 7) == 0) m0_cyc = 0;
      end else if ($urandom_range(0, 3) == 0) m0_cyc = 1;
      if (m1_cyc) begin
        if ($urandom_range(0, 7) == 0) m1_cyc = 0;
      end else if ($urandom_range(0, 3) == 0) m1_cyc = 1;
      m0_stb = m0_cyc & 1'($urandom_range(0, 1));
      m1_stb = m1_cyc & 1'($urandom_range(0, 1));
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_sel = 4'($urandom); m1_sel = 4'($urandom);
      m0_adr = $urandom; m1_adr = $urandom;
      m0_dat = $urandom; m1_dat = $urandom;
      s_dat = $urandom;
      s_int = 1'($urandom);
      s_ack = ($urandom_range(0, 99) < ack_pct);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
